// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg                                                                   |
// | State encodings and shared constants for the UART transmit arbiter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_SEND = 2'b01;
    localparam logic [1:0] c_WAIT = 2'b10;
    localparam logic [1:0] c_NEXT = 2'b11;

    // Message terminator used by the reporting sources
    localparam logic [7:0] c_UART_TERM = 8'h23;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational round-robin selector: first set request at or after ptr.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IDW     = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_SRC-1:0] grant_oh,
    output logic [IDW-1:0]     grant_idx,
    output logic               any
);

    always_comb begin
        int w_j;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            // ptr is always below NUM_SRC, so a single subtraction wraps
            w_j = int'(ptr) + k;
            if (w_j >= NUM_SRC) begin
                w_j = w_j - NUM_SRC;
            end
            if (!any && req[w_j]) begin
                any           = 1'b1;
                grant_oh[w_j] = 1'b1;
                grant_idx     = IDW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter                                                            |
// | Grants one UART transmitter to whole messages from NUM_SRC sources.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 50000,
    parameter int TOW     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req_valid,
    input  logic [8*NUM_SRC-1:0]   req_byte,
    input  logic [NUM_SRC-1:0]     req_last,
    output logic [NUM_SRC-1:0]     req_ready,
    output logic                   tx_data_valid,
    output logic [7:0]             tx_byte,
    input  logic                   tx_done,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam logic [TOW-1:0] c_WD_LIMIT = TOW'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_ptr;
    logic [TOW-1:0]     r_wdog;
    logic               r_last;
    logic [IDW-1:0]     r_grant_id;
    logic               r_tx_data_valid;
    logic [7:0]         r_tx_byte;
    logic               r_busy;
    logic               r_timeout_err;

    logic [NUM_SRC-1:0] w_pick_oh;
    logic [IDW-1:0]     w_pick_idx;
    logic               w_pick_any;
    logic [IDW-1:0]     w_sel_idx;
    logic [NUM_SRC-1:0] w_sel_oh;
    logic [7:0]         w_sel_byte;
    logic               w_sel_last;
    logic               w_own_valid;
    logic               w_take;
    logic               w_abort;
    logic [1:0]         w_nxt;
    logic [IDW-1:0]     w_ptr_after;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant_oh  (w_pick_oh),
        .grant_idx (w_pick_idx),
        .any       (w_pick_any)
    );

    // Byte source: the round-robin winner in IDLE, otherwise the message owner
    assign w_sel_idx = (r_state == c_IDLE) ? w_pick_idx : r_grant_id;

    always_comb begin
        w_sel_oh   = '0;
        w_sel_byte = 8'h00;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_sel_idx == IDW'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_byte  = req_byte[8*i +: 8];
                w_sel_last  = req_last[i];
            end
        end
    end

    assign w_own_valid = |(w_sel_oh & req_valid);
    assign w_ptr_after = IDW'(rr_next(int'(r_grant_id), NUM_SRC));

    assign req_ready = (r_state == c_IDLE) ? w_pick_oh :
                       (r_state == c_NEXT) ? (w_sel_oh & req_valid) : '0;

    always_comb begin
        w_nxt  = r_state;
        w_take = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pick_any) begin
                    w_nxt  = c_SEND;
                    w_take = 1'b1;
                end
            end
            c_SEND: begin
                if (!tx_done) begin
                    w_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (tx_done) begin
                    w_nxt = r_last ? c_IDLE : c_NEXT;
                end
            end
            default: begin
                if (w_own_valid) begin
                    w_nxt  = c_SEND;
                    w_take = 1'b1;
                end
            end
        endcase
        // Watchdog only fires when the phase would otherwise persist
        w_abort = (r_state != c_IDLE) && (w_nxt == r_state) && (r_wdog == c_WD_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_ptr           <= '0;
            r_wdog          <= '0;
            r_last          <= 1'b0;
            r_grant_id      <= '0;
            r_tx_data_valid <= 1'b0;
            r_tx_byte       <= 8'h00;
            r_busy          <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_timeout_err <= w_abort;
            if (w_abort) begin
                r_state         <= c_IDLE;
                r_wdog          <= '0;
                r_tx_data_valid <= 1'b0;
                r_busy          <= 1'b0;
                r_ptr           <= w_ptr_after;
            end else begin
                r_state <= w_nxt;
                if (w_nxt != r_state) begin
                    r_wdog <= '0;
                end else if (r_state != c_IDLE) begin
                    r_wdog <= r_wdog + TOW'(1);
                end
                if (w_take) begin
                    r_tx_byte       <= w_sel_byte;
                    r_last          <= w_sel_last;
                    r_tx_data_valid <= 1'b1;
                    r_busy          <= 1'b1;
                end
                if ((r_state == c_IDLE) && w_take) begin
                    r_grant_id <= w_pick_idx;
                end
                if ((r_state == c_SEND) && !tx_done) begin
                    r_tx_data_valid <= 1'b0;
                end
                if ((r_state == c_WAIT) && tx_done && r_last) begin
                    r_busy <= 1'b0;
                    r_ptr  <= w_ptr_after;
                end
            end
        end
    end

    assign tx_data_valid = r_tx_data_valid;
    assign tx_byte       = r_tx_byte;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                         |
// | Directed bench: message sources, UART model and per-scenario checks.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid;
    logic [23:0] req_byte;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        tx_data_valid;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_SRC (3),
        .IDW     (2),
        .TIMEOUT (20),
        .TOW     (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_byte      (req_byte),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data_valid (tx_data_valid),
        .tx_byte       (tx_byte),
        .tx_done       (tx_done),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Message sources
    logic [7:0] s_mem [3][64];
    bit         s_lst [3][64];
    int         s_len [3];
    int         s_pos [3];
    bit         s_flag [3];
    int         stall_at [3];
    int         stall_left [3];
    bit         uart_dead;

    always begin : p_src
        bit hold;
        bit have;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (s_flag[i]) s_pos[i]++;
            s_flag[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            have = (s_pos[i] < s_len[i]);
            hold = 1'b0;
            if (have && s_pos[i] == stall_at[i] && stall_left[i] > 0 &&
                busy && !tx_data_valid && tx_done) begin
                hold = 1'b1;
                stall_left[i]--;
            end
            req_valid[i]       = have && !hold;
            req_byte[8*i +: 8] = have ? s_mem[i][s_pos[i]] : 8'h00;
            req_last[i]        = have && s_lst[i][s_pos[i]];
        end
        #1;
        for (int i = 0; i < 3; i++) s_flag[i] = req_ready[i] && rst_n;
    end

    // UART: tx_done drops 3 cycles after a request, stays low 10 cycles
    int u_ph  = 0;
    int u_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n || uart_dead) begin
            tx_done = 1'b1;
            u_ph    = 0;
        end else begin
            case (u_ph)
                0: if (tx_data_valid) begin u_ph = 1; u_cnt = 0; end
                1: begin
                    u_cnt++;
                    if (u_cnt == 3) begin tx_done = 1'b0; u_ph = 2; u_cnt = 0; end
                end
                default: begin
                    u_cnt++;
                    if (u_cnt == 10) begin tx_done = 1'b1; u_ph = 0; end
                end
            endcase
        end
    end

    // Output log and protocol monitor
    logic [7:0] log_b [64];
    logic [1:0] log_g [64];
    int         log_cyc [64];
    int         log_n = 0;
    int         to_n = 0, cyc_to = 0;
    bit         to_txv, to_busy;
    int         fall_n = 0;
    bit         fall_prev_done, fall_prev2_done;
    int         viol = 0;
    bit         prev_v, prev_busy, prev_done, prev2_done;

    always begin : p_mon
        @(negedge clk);
        #3;
        if (!rst_n) begin
            prev_v = 0; prev_busy = 0; prev_done = 1; prev2_done = 1;
        end else begin
            if (tx_data_valid && !prev_v && log_n < 64) begin
                log_b[log_n]   = tx_byte;
                log_g[log_n]   = grant_id;
                log_cyc[log_n] = cyc;
                log_n++;
            end
            if (timeout_err) begin
                to_n++; cyc_to = cyc; to_txv = tx_data_valid; to_busy = busy;
            end
            if (prev_busy && !busy) begin
                fall_n++; fall_prev_done = prev_done; fall_prev2_done = prev2_done;
            end
            if ($countones(req_ready) > 1) viol++;
            if (busy && ((req_ready & ~(3'b001 << grant_id)) != 3'b000)) viol++;
            prev2_done = prev_done;
            prev_v = tx_data_valid; prev_busy = busy; prev_done = tx_done;
        end
    end

    task automatic add_str(input int s, input string m);
        for (int k = 0; k < m.len(); k++) begin
            s_mem[s][s_len[s]] = m[k];
            s_lst[s][s_len[s]] = (k == m.len() - 1);
            s_len[s]++;
        end
    endtask

    function automatic bit drained();
        return (s_pos[0] >= s_len[0]) && (s_pos[1] >= s_len[1]) && (s_pos[2] >= s_len[2]);
    endfunction

    task automatic clear_log();
        log_n = 0; to_n = 0; fall_n = 0; viol = 0;
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_len[i] = 0; s_pos[i] = 0; s_flag[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
        end
        uart_dead = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            #4;
            ok = !busy && !tx_data_valid && drained();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_done: busy=%0b still after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        int n;
        reset_assert();
        reset_release();
        repeat (2) @(negedge clk);
        #4;
        total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL rst_txv: got %0b want 0", tx_data_valid); end
        total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_byte: got %h want 00", tx_byte); end
        total++; if (busy !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rst_busy_gid: got %0b/%0d want 0/0", busy, grant_id); end
        add_str(2, "AB#");
        n = 0;
        while (!tx_data_valid && n < 20) begin @(negedge clk); #4; n++; end
        total++;
        if (!(tx_data_valid === 1'b1 && grant_id === 2'd2 && tx_byte === 8'h41)) begin
            bad++;
            $display("FAIL rst_pre_send: got v=%0b gid=%0d byte=%h want 1/2/41", tx_data_valid, grant_id, tx_byte);
        end
        // Reset lands mid-SEND; outputs must clear before any clock edge
        for (int i = 0; i < 3; i++) begin s_len[i] = 0; s_pos[i] = 0; s_flag[i] = 0; end
        rst_n = 1'b0;
        #1;
        total++;
        if ({tx_data_valid, tx_byte, grant_id, busy, timeout_err} !== 13'h0) begin
            bad++;
            $display("FAIL rst_async: got v=%0b byte=%h gid=%0d busy=%0b to=%0b want all 0",
                     tx_data_valid, tx_byte, grant_id, busy, timeout_err);
        end
        @(negedge clk);
        reset_release();
        repeat (3) @(negedge clk);
        #4;
        total++;
        if (busy !== 1'b0 || tx_data_valid !== 1'b0 || req_ready !== 3'b000) begin
            bad++;
            $display("FAIL rst_after: got busy=%0b v=%0b ready=%b want 0/0/000", busy, tx_data_valid, req_ready);
        end
    endtask

    task automatic test_single_source();
        string exp_s;
        logic [7:0] e;
        int gerr;
        exp_s = "SI-SIM1-P-#";
        reset_assert();
        add_str(0, exp_s);
        reset_release();
        wait_done(600, "single");
        total++; if (log_n !== 11) begin bad++; $display("FAIL single_count: got %0d want 11", log_n); end
        gerr = 0;
        for (int k = 0; k < 11; k++) begin
            e = exp_s[k];
            total++;
            if (log_b[k] !== e) begin bad++; $display("FAIL single_byte%0d: got %h want %h", k, log_b[k], e); end
            if (log_g[k] !== 2'd0) gerr++;
        end
        total++; if (gerr !== 0) begin bad++; $display("FAIL single_gid: got %0d wrong grants want 0", gerr); end
        total++;
        if (fall_n !== 1 || fall_prev_done !== 1'b1 || fall_prev2_done !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_fall: got falls=%0d done_before=%0b%0b want 1 and 01",
                     fall_n, fall_prev2_done, fall_prev_done);
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL single_ready: got %0d violations want 0", viol); end
    endtask

    task automatic test_round_robin();
        string exp_s;
        logic [7:0] e;
        int exp_g [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
        exp_s = "0a#1a#2a#0b#";
        reset_assert();
        add_str(0, "0a#");
        add_str(0, "0b#");
        add_str(1, "1a#");
        add_str(2, "2a#");
        reset_release();
        wait_done(1500, "rr");
        total++; if (log_n !== 12) begin bad++; $display("FAIL rr_count: got %0d want 12", log_n); end
        for (int k = 0; k < 12; k++) begin
            e = exp_s[k];
            total++;
            if (log_b[k] !== e || log_g[k] !== 2'(exp_g[k])) begin
                bad++;
                $display("FAIL rr_byte%0d: got %h/gid%0d want %h/gid%0d", k, log_b[k], log_g[k], e, exp_g[k]);
            end
        end
        total++; if (fall_n !== 4) begin bad++; $display("FAIL rr_msgs: got %0d busy falls want 4", fall_n); end
        total++; if (viol !== 0) begin bad++; $display("FAIL rr_ready: got %0d violations want 0", viol); end
    endtask

    task automatic test_stall_lock();
        string exp_s;
        logic [7:0] e;
        int exp_g [6] = '{1, 1, 1, 1, 2, 2};
        exp_s = "XYZ#Q#";
        reset_assert();
        add_str(1, "XYZ#");
        add_str(2, "Q#");
        stall_at[1]   = 1;
        stall_left[1] = 6;
        reset_release();
        wait_done(1000, "stall");
        total++; if (log_n !== 6) begin bad++; $display("FAIL stall_count: got %0d want 6", log_n); end
        for (int k = 0; k < 6; k++) begin
            e = exp_s[k];
            total++;
            if (log_b[k] !== e || log_g[k] !== 2'(exp_g[k])) begin
                bad++;
                $display("FAIL stall_byte%0d: got %h/gid%0d want %h/gid%0d", k, log_b[k], log_g[k], e, exp_g[k]);
            end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL stall_lock: got %0d foreign readies want 0", viol); end
        total++; if (to_n !== 0) begin bad++; $display("FAIL stall_timeout: got %0d aborts want 0", to_n); end
    endtask

    task automatic test_timeout();
        int n;
        reset_assert();
        uart_dead = 1'b1;
        add_str(0, "TU#");
        add_str(1, "V#");
        reset_release();
        n = 0;
        while (to_n == 0 && n < 60) begin @(negedge clk); #4; n++; end
        total++;
        if (to_n == 0 || log_n < 1) begin
            bad++;
            $display("FAIL to_seen: got pulses=%0d sends=%0d want 1/1", to_n, log_n);
        end else begin
            total++;
            if (cyc_to - log_cyc[0] !== 20) begin
                bad++;
                $display("FAIL to_latency: got %0d cycles want 20", cyc_to - log_cyc[0]);
            end
            total++;
            if (to_txv !== 1'b0 || to_busy !== 1'b0) begin
                bad++;
                $display("FAIL to_outputs: got v=%0b busy=%0b want 0/0", to_txv, to_busy);
            end
            total++;
            if (log_b[0] !== 8'h54 || log_g[0] !== 2'd0) begin
                bad++;
                $display("FAIL to_first: got %h/gid%0d want 54/gid0", log_b[0], log_g[0]);
            end
        end
        n = 0;
        while (log_n < 2 && n < 10) begin @(negedge clk); #4; n++; end
        total++;
        if (log_n < 2 || log_g[1] !== 2'd1 || log_b[1] !== 8'h56) begin
            bad++;
            $display("FAIL to_ptr_adv: got sends=%0d next=%h/gid%0d want 2 and 56/gid1",
                     log_n, log_b[1], log_g[1]);
        end
        total++; if (to_n !== 1) begin bad++; $display("FAIL to_pulse: got %0d pulse cycles want 1", to_n); end
    endtask

    task automatic test_single_byte();
        reset_assert();
        add_str(2, "A");
        reset_release();
        wait_done(200, "onebyte");
        repeat (5) @(negedge clk);
        #4;
        total++;
        if (log_n !== 1 || log_b[0] !== 8'h41 || log_g[0] !== 2'd2) begin
            bad++;
            $display("FAIL onebyte_send: got n=%0d %h/gid%0d want 1 41/gid2", log_n, log_b[0], log_g[0]);
        end
        total++;
        if (busy !== 1'b0 || fall_n !== 1) begin
            bad++;
            $display("FAIL onebyte_busy: got busy=%0b falls=%0d want 0/1", busy, fall_n);
        end
    endtask

    initial begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        tx_done   = 1'b1;
        uart_dead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_len[i] = 0; s_pos[i] = 0; s_flag[i] = 0; stall_at[i] = -1; stall_left[i] = 0;
        end
        test_reset();
        test_single_source();
        test_round_robin();
        test_stall_lock();
        test_timeout();
        test_single_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
